jogador_automatico: RTL and testbench

//  Hardware auto-player for the memory game (jogo_desafio_memoria_desafio): watches
//  the game's leds, records each displayed colour, replays the round on botoes.

---
 rtl/jogador_pkg.sv | 25 ++
 rtl/jogador_automatico_if.sv | 25 ++
 rtl/temporizador_jogador.sv | 25 ++
 rtl/jogador_automatico.sv | 162 ++++++++++++++++
 tb/tb_jogador_automatico.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jogador_pkg.sv
// Shared state encoding and default timing for the memory-game auto-player.
package jogador_pkg;

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    ESPERA_LED = 3'd1,
    GRAVA      = 3'd2,
    LACUNA     = 3'd3,
    PRESSIONA  = 3'd4,
    SOLTA      = 3'd5,
    FIM        = 3'd6
  } estado_t;

  localparam int DEPTH_PADRAO    = 16;
  localparam int T_PRESS_PADRAO  = 10;
  localparam int T_SOLTA_PADRAO  = 10;
  localparam int IDLE_GAP_PADRAO = 1200;

  function automatic int maximo3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jogador_automatico_if.sv
// Game-side and control signals of the auto-player; slave is the player itself.
interface jogador_automatico_if;
  logic       habilita;
  logic [3:0] leds;
  logic       ganhou;
  logic       perdeu;
  logic       pronto;
  logic       erro_en;
  logic [3:0] erro_pos;
  logic [3:0] botoes;
  logic       ocupado;
  logic [4:0] rodadas;
  logic       erro_capacidade;
  logic [2:0] db_estado;

  modport master (
    output habilita, leds, ganhou, perdeu, pronto, erro_en, erro_pos,
    input  botoes, ocupado, rodadas, erro_capacidade, db_estado
  );

  modport slave (
    input  habilita, leds, ganhou, perdeu, pronto, erro_en, erro_pos,
    output botoes, ocupado, rodadas, erro_capacidade, db_estado
  );
endinterface

// File: rtl/temporizador_jogador.sv
// Loadable down-counter; fim is high while the count sits at zero (it never wraps).
module temporizador_jogador #(
  parameter int W = 11
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carga,
  input  logic         conta,
  input  logic [W-1:0] valor,
  output logic         fim
);
  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (carga) begin
      cnt <= valor;
    end else if (conta && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign fim = (cnt == '0);
endmodule

// File: rtl/jogador_automatico.sv
// Auto-player for the memory game: records the colours shown on leds and replays
// them on botoes, optionally corrupting one press to force a loss.
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int DEPTH    = DEPTH_PADRAO,
  parameter int T_PRESS  = T_PRESS_PADRAO,
  parameter int T_SOLTA  = T_SOLTA_PADRAO,
  parameter int IDLE_GAP = IDLE_GAP_PADRAO
) (
  input logic clock,
  input logic reset,
  jogador_automatico_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(maximo3(T_PRESS, T_SOLTA, IDLE_GAP));

  estado_t       estado, prox_estado;
  logic [3:0]    leds_q, leds_ant;
  logic [3:0]    mem [DEPTH];
  logic [CW-1:0] contagem;
  logic [PW-1:0] ponteiro;
  logic [4:0]    rodadas;
  logic          erro_capacidade;
  logic          evento, parada, cheio, ultimo;
  logic          grava, inicia, avanca, fecha;
  logic          tmr_carga, tmr_conta, tmr_fim;
  logic [TW-1:0] tmr_valor;
  logic [3:0]    tecla;

  assign evento = (leds_q != 4'd0) && (leds_ant == 4'd0);
  assign parada = bus.ganhou | bus.perdeu | bus.pronto;
  assign cheio  = (contagem == CW'(DEPTH));
  assign ultimo = (CW'(ponteiro) == (contagem - CW'(1)));

  // One timer serves the display gap, the press hold and the release time;
  // it is reloaded on every edge that enters a timed state.
  assign tmr_conta = (estado == LACUNA) || (estado == PRESSIONA) || (estado == SOLTA);

  temporizador_jogador #(.W(TW)) u_tempo (
    .clock (clock),
    .reset (reset),
    .carga (tmr_carga),
    .conta (tmr_conta),
    .valor (tmr_valor),
    .fim   (tmr_fim)
  );

  always_comb begin
    prox_estado = estado;
    grava       = 1'b0;
    inicia      = 1'b0;
    avanca      = 1'b0;
    fecha       = 1'b0;
    tmr_carga   = 1'b0;
    tmr_valor   = '0;
    unique case (estado)
      OCIOSO:     if (bus.habilita) prox_estado = ESPERA_LED;
      ESPERA_LED: if (evento) begin
        grava       = 1'b1;
        prox_estado = GRAVA;
      end
      GRAVA: if (leds_q == 4'd0) begin
        prox_estado = LACUNA;
        tmr_carga   = 1'b1;
        tmr_valor   = TW'(IDLE_GAP - 1);
      end
      LACUNA: begin
        if (evento) begin
          grava       = 1'b1;
          prox_estado = GRAVA;
        end else if (tmr_fim) begin
          if (contagem != '0) begin
            prox_estado = PRESSIONA;
            inicia      = 1'b1;
            tmr_carga   = 1'b1;
            tmr_valor   = TW'(T_PRESS - 1);
          end else begin
            prox_estado = ESPERA_LED;
          end
        end
      end
      PRESSIONA: if (tmr_fim) begin
        prox_estado = SOLTA;
        tmr_carga   = 1'b1;
        tmr_valor   = TW'(T_SOLTA - 1);
      end
      SOLTA: if (tmr_fim) begin
        if (ultimo) begin
          fecha       = 1'b1;
          prox_estado = ESPERA_LED;
        end else begin
          avanca      = 1'b1;
          prox_estado = PRESSIONA;
          tmr_carga   = 1'b1;
          tmr_valor   = TW'(T_PRESS - 1);
        end
      end
      FIM:     begin end
      default: prox_estado = OCIOSO;
    endcase
    // Disable beats the stop inputs, which beat any normal transition and its side effects.
    if (!bus.habilita || parada) begin
      prox_estado = bus.habilita ? FIM : OCIOSO;
      grava       = 1'b0;
      inicia      = 1'b0;
      avanca      = 1'b0;
      fecha       = 1'b0;
      tmr_carga   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado          <= OCIOSO;
      leds_q          <= 4'd0;
      leds_ant        <= 4'd0;
      contagem        <= '0;
      ponteiro        <= '0;
      rodadas         <= 5'd0;
      erro_capacidade <= 1'b0;
    end else begin
      estado   <= prox_estado;
      leds_q   <= bus.leds;
      leds_ant <= leds_q;
      if (estado == OCIOSO) begin
        contagem <= '0;
        ponteiro <= '0;
      end
      if (grava) begin
        if (cheio) erro_capacidade <= 1'b1;
        else       contagem <= contagem + CW'(1);
      end
      if (inicia) ponteiro <= '0;
      if (avanca) ponteiro <= ponteiro + PW'(1);
      if (fecha) begin
        contagem <= '0;
        if (rodadas != 5'd31) rodadas <= rodadas + 5'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset && grava && !cheio) mem[contagem[PW-1:0]] <= leds_q;
  end

  always_comb begin
    tecla = 4'd0;
    if (estado == PRESSIONA) begin
      tecla = mem[ponteiro];
      if (bus.erro_en && (CW'(bus.erro_pos) == CW'(ponteiro)))
        tecla = {mem[ponteiro][2:0], mem[ponteiro][3]};
    end
  end

  assign bus.botoes          = tecla;
  assign bus.ocupado         = (estado != OCIOSO) && (estado != FIM);
  assign bus.rodadas         = rodadas;
  assign bus.erro_capacidade = erro_capacidade;
  assign bus.db_estado       = estado;
endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: random rounds against a colour-list model, press
// scoreboard checked by an independent monitor, plus directed stop/reset cases.
module tb_jogador_automatico;
  import jogador_pkg::*;

  localparam int DEPTH    = 16;
  localparam int T_PRESS  = 10;
  localparam int T_SOLTA  = 10;
  localparam int IDLE_GAP = 300;

  typedef logic [3:0] cor_t;

  logic clk = 1'b0;
  logic rst_n;
  jogador_automatico_if bus ();

  jogador_automatico #(
    .DEPTH(DEPTH), .T_PRESS(T_PRESS), .T_SOLTA(T_SOLTA), .IDLE_GAP(IDLE_GAP)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  m_rodadas = 0;
  bit  m_cap     = 1'b0;
  bit  mon_en    = 1'b0;

  task automatic check(input string nome, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nome, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: pops one expected press per rising press, checks hold and release lengths
  initial begin
    logic [3:0] b, prev;
    int len, gap;
    bit seen;
    prev = 4'd0; len = 0; gap = 0; seen = 1'b0;
    forever begin
      @(negedge clk);
      b = bus.botoes;
      if (!mon_en) begin
        prev = 4'd0; len = 0; gap = 0; seen = 1'b0;
      end else begin
        if (b != 4'd0 && prev == 4'd0) begin
          if (seen) check("solta_min", (gap < T_SOLTA) ? gap : T_SOLTA, T_SOLTA);
          if (exp_q.size() == 0) check("press_extra", int'(b), 0);
          else check("press_val", int'(b), int'(exp_q.pop_front()));
          len = 1;
        end else if (b != 4'd0) begin
          len++;
        end else if (prev != 4'd0) begin
          check("press_len", len, T_PRESS);
          gap  = 1;
          seen = 1'b1;
        end else begin
          gap++;
        end
        prev = b;
      end
    end
  end

  // reference: stored = first DEPTH colours, one position rotated left if enabled
  task automatic push_modelo(input cor_t cores[$], input bit er_en, input int er_pos);
    int n;
    cor_t v;
    n = (cores.size() > DEPTH) ? DEPTH : cores.size();
    if (cores.size() > DEPTH) m_cap = 1'b1;
    for (int i = 0; i < n; i++) begin
      v = cores[i];
      if (er_en && i == er_pos) v = cor_t'(((v << 1) | (v >> 3)) & 4'hF);
      exp_q.push_back(v);
    end
  endtask

  task automatic show(input cor_t cores[$]);
    foreach (cores[i]) begin
      bus.leds = cores[i];
      repeat ($urandom_range(1, 30)) step();
      bus.leds = 4'd0;
      repeat ($urandom_range(1, 50)) step();
    end
  endtask

  task automatic wait_estado(input string nome, input estado_t alvo);
    int k;
    for (k = 0; k < 4000; k++) begin
      if (bus.db_estado == alvo) break;
      step();
    end
    if (k == 4000) check(nome, int'(bus.db_estado), int'(alvo));
  endtask

  task automatic fim_rodada(input string nome);
    int k;
    for (k = 0; k < 4000; k++) begin
      step();
      if (exp_q.size() == 0 && bus.db_estado == ESPERA_LED && bus.botoes == 4'd0) break;
    end
    if (k == 4000) check({nome, "_timeout"}, exp_q.size(), 0);
    if (m_rodadas < 31) m_rodadas++;
    check({nome, "_rodadas"}, int'(bus.rodadas), m_rodadas);
    check({nome, "_cap"}, int'(bus.erro_capacidade), int'(m_cap));
  endtask

  task automatic run_round(input string nome, input cor_t cores[$], input bit er_en,
                           input int er_pos);
    bus.erro_en  = er_en;
    bus.erro_pos = 4'(er_pos);
    push_modelo(cores, er_en, er_pos);
    show(cores);
    fim_rodada(nome);
  endtask

  initial begin
    cor_t cores[$];
    int k;
    rst_n = 1'b0;
    bus.habilita = 1'b0; bus.leds = 4'd0; bus.ganhou = 1'b0; bus.perdeu = 1'b0;
    bus.pronto = 1'b0; bus.erro_en = 1'b0; bus.erro_pos = 4'd0;
    repeat (3) step();
    check("rst_estado", int'(bus.db_estado), int'(OCIOSO));
    check("rst_botoes", int'(bus.botoes), 0);
    check("rst_ocupado", int'(bus.ocupado), 0);
    check("rst_rodadas", int'(bus.rodadas), 0);
    check("rst_cap", int'(bus.erro_capacidade), 0);
    rst_n = 1'b1;
    step();
    check("ocioso_hold", int'(bus.db_estado), int'(OCIOSO));
    bus.habilita = 1'b1;
    step();
    check("espera", int'(bus.db_estado), int'(ESPERA_LED));
    check("ocupado", int'(bus.ocupado), 1);
    mon_en = 1'b1;

    // long single colour, then exact latency from leds falling to the first press
    exp_q.push_back(4'b0001);
    bus.leds = 4'b0001;
    repeat (1000) step();
    bus.leds = 4'd0;
    for (k = 1; k <= 3 * IDLE_GAP; k++) begin
      step();
      if (bus.botoes != 4'd0) break;
    end
    check("latencia", k, IDLE_GAP + 2);
    fim_rodada("unica");

    cores = '{4'b0001, 4'b0010, 4'b0100};
    run_round("corrompe", cores, 1'b1, 2);

    for (int r = 0; r < 8; r++) begin
      cores.delete();
      repeat ($urandom_range(1, DEPTH)) cores.push_back(cor_t'($urandom_range(1, 15)));
      run_round("aleat", cores, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
    end

    cores.delete();
    repeat (DEPTH + 1) cores.push_back(cor_t'($urandom_range(1, 15)));
    run_round("capacidade", cores, 1'b0, 0);

    // perdeu during the first release: stop immediately, remaining presses dropped
    cores = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    bus.erro_en = 1'b0;
    push_modelo(cores, 1'b0, 0);
    show(cores);
    wait_estado("espera_solta", SOLTA);
    bus.perdeu = 1'b1;
    step();
    bus.perdeu = 1'b0;
    check("perdeu_fim", int'(bus.db_estado), int'(FIM));
    check("perdeu_ocupado", int'(bus.ocupado), 0);
    exp_q.delete();
    repeat (30) step();
    check("fim_hold", int'(bus.db_estado), int'(FIM));
    check("fim_botoes", int'(bus.botoes), 0);
    bus.habilita = 1'b0;
    step();
    check("desabilita", int'(bus.db_estado), int'(OCIOSO));
    bus.habilita = 1'b1;
    step();
    check("reinicia", int'(bus.db_estado), int'(ESPERA_LED));
    cores = '{4'b0010, 4'b1000};
    run_round("apos_fim", cores, 1'b0, 0);

    bus.ganhou = 1'b1;
    step();
    bus.ganhou = 1'b0;
    check("ganhou_fim", int'(bus.db_estado), int'(FIM));
    bus.habilita = 1'b0;
    step();
    bus.habilita = 1'b1;
    step();

    // reset in the middle of a press
    mon_en = 1'b0;
    cores = '{4'b0100, 4'b0001, 4'b1000};
    show(cores);
    wait_estado("espera_press", PRESSIONA);
    rst_n = 1'b0;
    step();
    check("rst_mid_botoes", int'(bus.botoes), 0);
    check("rst_mid_estado", int'(bus.db_estado), int'(OCIOSO));
    check("rst_mid_rodadas", int'(bus.rodadas), 0);
    check("rst_mid_cap", int'(bus.erro_capacidade), 0);
    rst_n = 1'b1;
    m_rodadas = 0;
    m_cap = 1'b0;
    step();
    check("rst_mid_espera", int'(bus.db_estado), int'(ESPERA_LED));
    mon_en = 1'b1;

    for (int r = 0; r < 32; r++) begin
      cores = '{cor_t'($urandom_range(1, 15))};
      run_round("satura", cores, 1'b0, 0);
    end

    check("fila_vazia", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
